// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply and restoring divide,
// one iteration per clock, results posted to hi/lo with a one-cycle done pulse.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mult_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             qbit;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] m;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_trial;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] q_step;
  logic             qbit_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign a_mag    = a[WIDTH-1] ? -a : a;
  assign b_mag    = b[WIDTH-1] ? -b : b;
  assign quot_fix = neg_q ? -qreg : qreg;
  assign rem_fix  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  // acc carries one guard bit so Booth add/subtract of the most-negative value cannot overflow
  always_comb begin
    m_ext     = {m[WIDTH-1], m};
    booth_sum = acc;
    case ({qreg[0], qbit})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    rem_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, m};
    if (is_div) begin
      qbit_step = qbit;
      if (!rem_trial[WIDTH]) begin
        acc_step = rem_trial;
        q_step   = {qreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = rem_shift;
        q_step   = {qreg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      q_step    = {booth_sum[0], qreg[WIDTH-1:1]};
      qbit_step = qreg[0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      qbit   <= 1'b0;
      acc    <= '0;
      qreg   <= '0;
      m      <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state)
        IDLE: begin
          if (mult_div == 2'b01) begin
            is_div <= 1'b0;
            acc    <= '0;
            qreg   <= b;
            m      <= a;
            qbit   <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else if (mult_div == 2'b10) begin
            if (b == '0) begin
              done <= 1'b1;
              div0 <= 1'b1;
            end else begin
              is_div <= 1'b1;
              acc    <= '0;
              qreg   <= a_mag;
              m      <= b_mag;
              qbit   <= 1'b0;
              neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r  <= a[WIDTH-1];
              count  <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= acc_step;
          qreg  <= q_step;
          qbit  <= qbit_step;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) state <= FINISH;
        end
        FINISH: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= acc[WIDTH-1:0];
            lo <= qreg;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: Booth multiply, signed divide,
// divide-by-zero, asynchronous reset mid-operation and request handling.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mult_div = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div0;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .mult_div(mult_div), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clock = ~clock;

  // drive a request so that the next rising edge (edge k) samples it
  task automatic start(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    mult_div = op;
    a = x;
    b = y;
    @(posedge clock);
  endtask

  // called at the negedge after edge k; returns edges from k until done is seen (200 = timeout)
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mult_div = 2'b01;
    a = 32'd7;
    b = 32'd3;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h expected %h", hi, 32'h0); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h expected %h", lo, 32'h0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", busy); end
    tests++; if ({done, div0} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b expected 00", {done, div0}); end
    mult_div = 2'b00;
    reset = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start(op, x, y);
    @(negedge clock);
    mult_div = 2'b00;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy got %b expected 1", name, busy); end
    wait_done(n);
    tests++; if (n !== 33) begin fails++; $display("FAIL %s_latency got %0d expected 33", name, n); end
    tests++; if (hi !== exp_hi) begin fails++; $display("FAIL %s_hi got %h expected %h", name, hi, exp_hi); end
    tests++; if (lo !== exp_lo) begin fails++; $display("FAIL %s_lo got %h expected %h", name, lo, exp_lo); end
    tests++; if ({busy, div0} !== 2'b00) begin fails++; $display("FAIL %s_done_flags got %b expected 00", name, {busy, div0}); end
    @(negedge clock);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL %s_done_pulse got %b expected 0", name, done); end
    $display("[TB] %s a=%h b=%h -> hi=%h lo=%h", name, x, y, hi, lo);
  endtask

  task automatic test_mult;
    run_check("mul_7_m3", 2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_check("mul_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_check("mul_max_min", 2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
    run_check("mul_m1_m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
  endtask

  task automatic test_div;
    run_check("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_check("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_check("div_7_m2", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_check("div_m7_m2", 2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003);
  endtask

  task automatic test_div0;
    run_check("preload", 2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    start(2'b11, 32'h1234_5678, 32'h0000_0001);
    @(negedge clock);
    mult_div = 2'b00;
    tests++; if ({busy, done, div0} !== 3'b000) begin fails++; $display("FAIL op11_flags got %b expected 000", {busy, done, div0}); end
    start(2'b10, 32'h0000_0005, 32'h0000_0000);
    @(negedge clock);
    mult_div = 2'b00;
    tests++; if ({done, div0} !== 2'b11) begin fails++; $display("FAIL div0_flags got %b expected 11", {done, div0}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL div0_busy got %b expected 0", busy); end
    tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin fails++; $display("FAIL div0_hilo got %h expected %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB); end
    @(negedge clock);
    tests++; if ({busy, done, div0} !== 3'b000) begin fails++; $display("FAIL div0_pulse got %b expected 000", {busy, done, div0}); end
    $display("[TB] div 5/0 -> div0 pulse, hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_reset_mid_run;
    int n;
    start(2'b01, 32'h0000_0007, 32'hFFFF_FFFD);
    @(negedge clock);
    mult_div = 2'b00;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL midrst_hilo got %h expected 0", {hi, lo}); end
    tests++; if ({busy, done, div0} !== 3'b000) begin fails++; $display("FAIL midrst_flags got %b expected 000", {busy, done, div0}); end
    @(negedge clock);
    reset = 1'b0;
    mult_div = 2'b10;
    a = 32'd100;
    b = 32'd7;
    @(posedge clock);
    @(negedge clock);
    mult_div = 2'b00;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL postrst_busy got %b expected 1", busy); end
    wait_done(n);
    tests++; if (n !== 33) begin fails++; $display("FAIL postrst_latency got %0d expected 33", n); end
    tests++; if (lo !== 32'd14) begin fails++; $display("FAIL postrst_lo got %h expected %h", lo, 32'd14); end
    tests++; if (hi !== 32'd2) begin fails++; $display("FAIL postrst_hi got %h expected %h", hi, 32'd2); end
    $display("[TB] reset mid-mult, then div 100/7 -> hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_back_to_back;
    int n;
    start(2'b01, 32'h0000_0007, 32'hFFFF_FFFD);
    n = 0;
    @(negedge clock);
    while (done !== 1'b1 && n < 200) begin
      mult_div = n[0] ? 2'b01 : 2'b10;
      a = 32'hDEAD_0000 + n;
      b = 32'h0000_0000;
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    tests++; if (n !== 33) begin fails++; $display("FAIL toggle_latency got %0d expected 33", n); end
    tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin fails++; $display("FAIL toggle_hilo got %h expected %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB); end
    $display("[TB] mult 7*-3 with toggling requests -> hi=%h lo=%h", hi, lo);
    mult_div = 2'b10;
    a = 32'd100;
    b = 32'd7;
    @(posedge clock);
    @(negedge clock);
    mult_div = 2'b00;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b expected 1", busy); end
    wait_done(n);
    tests++; if (n !== 33) begin fails++; $display("FAIL b2b_latency got %0d expected 33", n); end
    tests++; if ({hi, lo} !== {32'd2, 32'd14}) begin fails++; $display("FAIL b2b_hilo got %h expected %h", {hi, lo}, {32'd2, 32'd14}); end
    $display("[TB] div 100/7 accepted in done cycle -> hi=%h lo=%h", hi, lo);
    repeat (5) @(negedge clock);
    tests++; if ({hi, lo} !== {32'd2, 32'd14}) begin fails++; $display("FAIL hold_hilo got %h expected %h", {hi, lo}, {32'd2, 32'd14}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
